// File: rtl/cache_meta_store.sv
// cache_meta_store: N-way tag/valid/dirty/tree-PLRU metadata store with registered hit/victim lookup, fill, mark-dirty, and a flush/writeback sweep when CACHE_META_FLUSH_EN is defined (ports: lookup_*/resp, fill_*, mark_*, flush_*, wb_*)
module cache_meta_store #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
  parameter int S_WAY    = $clog2(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid,
  input  logic [31:0]        lookup_addr,
  output logic               resp_valid,
  output logic               hit,
  output logic [S_WAY-1:0]   hit_way,
  output logic [S_WAY-1:0]   victim_way,
  output logic               victim_dirty,
  output logic [S_TAG-1:0]   victim_tag,
  input  logic               fill_en,
  input  logic [S_WAY-1:0]   fill_way,
  input  logic [31:0]        fill_addr,
  input  logic               fill_dirty,
  input  logic               mark_dirty_en,
  input  logic [S_WAY-1:0]   mark_way,
  input  logic [S_INDEX-1:0] mark_index,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [S_INDEX-1:0] wb_index,
  output logic [S_WAY-1:0]   wb_way,
  output logic [S_TAG-1:0]   wb_tag
);
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int S_PTR = S_INDEX + S_WAY;
  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty [NUM_SETS];
  logic [S_TAG-1:0] tag [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-2:0] plru [NUM_SETS];
  logic busy, wb_clr, lk, fe, md, l_hit, unused_ok;
  logic [S_INDEX-1:0] l_idx, f_idx, p_idx;
  logic [S_TAG-1:0] l_tag, f_tag;
  logic [S_WAY-1:0] l_way, l_vic, p_way;
  function automatic logic [S_WAY-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
    logic [NUM_WAYS-2:0] s;
    int n;
    n = 0;
    for (int l = 0; l < S_WAY; l++) begin
      s = t >> n;
      n = 2 * n + 1 + int'(s[0]);
    end
    return S_WAY'(n - NUM_WAYS + 1);
  endfunction
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t, input logic [S_WAY-1:0] w);
    logic [NUM_WAYS-2:0] r, m;
    logic [S_WAY-1:0] v;
    logic d;
    int n;
    r = t;
    v = w;
    n = 0;
    for (int l = 0; l < S_WAY; l++) begin
      d = v[S_WAY-1];
      v = v << 1;
      m = (NUM_WAYS-1)'(1) << n;
      r = d ? (r & ~m) : (r | m);
      n = 2 * n + 1 + int'(d);
    end
    return r;
  endfunction
  assign l_idx = lookup_addr[S_OFFSET +: S_INDEX];
  assign l_tag = lookup_addr[31 -: S_TAG];
  assign f_idx = fill_addr[S_OFFSET +: S_INDEX];
  assign f_tag = fill_addr[31 -: S_TAG];
  assign lk = lookup_valid & ~busy;
  assign fe = fill_en & ~busy;
  assign md = mark_dirty_en & ~busy;
  assign unused_ok = ^{lookup_addr[S_OFFSET-1:0], fill_addr[S_OFFSET-1:0], flush_req, wb_ready};
  always_comb begin
    logic [S_WAY-1:0] wi;
    l_hit = 1'b0;
    l_way = '0;
    l_vic = plru_victim(plru[l_idx]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      wi = S_WAY'(w);
      if (valid[l_idx][wi] && tag[l_idx][wi] == l_tag) begin
        l_hit = 1'b1;
        l_way = wi;
      end
      if (!valid[l_idx][wi]) l_vic = wi;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '{default: '0};
      dirty <= '{default: '0};
      tag <= '{default: '{default: '0}};
      plru <= '{default: '0};
      resp_valid <= 1'b0;
      hit <= 1'b0;
      hit_way <= '0;
      victim_way <= '0;
      victim_dirty <= 1'b0;
      victim_tag <= '0;
    end else begin
      resp_valid <= lk;
      if (lk) begin
        hit <= l_hit;
        hit_way <= l_way;
        victim_way <= l_vic;
        victim_dirty <= valid[l_idx][l_vic] & dirty[l_idx][l_vic];
        victim_tag <= tag[l_idx][l_vic];
      end
      if (lk && l_hit) plru[l_idx] <= plru_touch(plru[l_idx], l_way);
      if (fe) begin
        tag[f_idx][fill_way] <= f_tag;
        valid[f_idx][fill_way] <= 1'b1;
        dirty[f_idx][fill_way] <= fill_dirty;
        plru[f_idx] <= plru_touch((lk && l_hit && l_idx == f_idx) ? plru_touch(plru[l_idx], l_way) : plru[f_idx], fill_way);
      end
      if (md) dirty[mark_index][mark_way] <= 1'b1;
      if (wb_clr) dirty[p_idx][p_way] <= 1'b0;
    end
`ifdef CACHE_META_FLUSH_EN
  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
  state_t state, state_nx;
  logic [S_PTR-1:0] ptr, ptr_nx;
  logic last, p_dirty;
  assign p_idx = ptr[S_PTR-1 -: S_INDEX];
  assign p_way = ptr[S_WAY-1:0];
  assign last = &ptr;
  assign p_dirty = valid[p_idx][p_way] & dirty[p_idx][p_way];
  assign busy = state != IDLE;
  assign flush_busy = busy;
  assign flush_done = state == DONE;
  assign wb_valid = state == WB;
  assign wb_index = wb_valid ? p_idx : '0;
  assign wb_way = wb_valid ? p_way : '0;
  assign wb_tag = wb_valid ? tag[p_idx][p_way] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
    end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    wb_clr = 1'b0;
    case (state)
      IDLE: if (flush_req) begin
        state_nx = SCAN;
        ptr_nx = '0;
      end
      SCAN: begin
        state_nx = p_dirty ? WB : last ? DONE : SCAN;
        ptr_nx = (p_dirty || last) ? ptr : ptr + 1'b1;
      end
      WB: if (wb_ready) begin
        wb_clr = 1'b1;
        state_nx = last ? DONE : SCAN;
        ptr_nx = last ? ptr : ptr + 1'b1;
      end
      DONE: state_nx = IDLE;
    endcase
  end
`else
  assign busy = 1'b0;
  assign wb_clr = 1'b0;
  assign p_idx = '0;
  assign p_way = '0;
  assign flush_busy = 1'b0;
  assign flush_done = 1'b0;
  assign wb_valid = 1'b0;
  assign wb_index = '0;
  assign wb_way = '0;
  assign wb_tag = '0;
`endif
endmodule
